// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter slice.
//   bus_cmd_t : memory bus command encoding (BUS_NONE / BUS_LOAD / BUS_STORE)
//   TAG_W     : width of memory transaction tags (tag 0 means "none")
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_t;

  localparam int unsigned TAG_W = 4;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Tracks which side (I or D) owns each outstanding memory tag 1..15.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   set_en            : record ownership of set_tag this edge
//   set_tag           : tag issued by memory for the granted command
//   set_is_d          : owner of set_tag is the D-side
//   lookup_tag        : tag currently returning from memory (0 = none)
//   hit               : lookup_tag has a recorded owner
//   hit_is_d          : recorded owner of lookup_tag is the D-side
//   orphan            : nonzero lookup_tag with no recorded owner
// A hit frees the entry at the next edge; a simultaneous set of the same
// entry takes precedence so a reissued tag keeps its new owner.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             set_is_d,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic             hit_is_d,
  output logic             orphan
);

  logic [15:1] owner_valid;
  logic [15:1] owner_is_d;

  always_comb begin
    hit      = 1'b0;
    hit_is_d = 1'b0;
    for (int unsigned i = 1; i < 16; i++) begin
      if (lookup_tag == TAG_W'(i)) begin
        hit      = owner_valid[i];
        hit_is_d = owner_is_d[i];
      end
    end
    orphan = (lookup_tag != '0) && !hit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_valid <= '0;
      owner_is_d  <= '0;
    end else begin
      for (int unsigned i = 1; i < 16; i++) begin
        if (set_en && set_tag == TAG_W'(i)) begin
          owner_valid[i] <= 1'b1;
          owner_is_d[i]  <= set_is_d;
        end else if (hit && lookup_tag == TAG_W'(i)) begin
          owner_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single tagged memory port between the I-cache and D-cache
// controllers and steers returning tags/data back to their owner.
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   Icache2mem_*            : I-side load request (command, address)
//   Dcache2mem_*            : D-side load/store request (command, address, data)
//   mem2proc_response       : tag memory issued for this cycle's command (0 = refused)
//   mem2proc_tag/_data      : returning transaction (tag 0 = none)
//   proc2mem_*              : command/address/data of the granted side
//   Imem2Icache_*           : response and returned tag/data routed to I-side
//   Dmem2Dcache_*           : response and returned tag/data routed to D-side
//   grant_i                 : I-side granted this cycle
//   orphan_tag              : nonzero returning tag with no recorded owner
// D-side wins by default; after STARVE_LIMIT consecutive denied I-side cycles
// the I-side is granted until memory accepts its request.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_BITS     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Icache2mem_command,
  input  logic [63:0]      Icache2mem_addr,
  input  logic [1:0]       Dcache2mem_command,
  input  logic [63:0]      Dcache2mem_addr,
  input  logic [63:0]      Dcache2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [TAG_W-1:0] mem2proc_tag,
  input  logic [63:0]      mem2proc_data,
  output logic [1:0]       proc2mem_command,
  output logic [63:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] Imem2Icache_response,
  output logic [TAG_W-1:0] Imem2Icache_tag,
  output logic [63:0]      Imem2Icache_data,
  output logic [TAG_W-1:0] Dmem2Dcache_response,
  output logic [TAG_W-1:0] Dmem2Dcache_tag,
  output logic [63:0]      Dmem2Dcache_data,
  output logic             grant_i,
  output logic             orphan_tag
);

  logic                i_active;
  logic                d_active;
  logic                grant_d;
  logic                accepted;
  logic [CNT_BITS-1:0] starve_cnt;
  logic                hit;
  logic                hit_is_d;

  assign i_active = (Icache2mem_command != BUS_NONE);
  assign d_active = (Dcache2mem_command != BUS_NONE);
  assign grant_i  = i_active && (!d_active || starve_cnt >= CNT_BITS'(STARVE_LIMIT));
  assign grant_d  = d_active && !grant_i;
  assign accepted = (grant_i || grant_d) && (mem2proc_response != '0);

  always_comb begin
    proc2mem_command     = BUS_NONE;
    proc2mem_addr        = '0;
    proc2mem_data        = '0;
    Imem2Icache_response = '0;
    Dmem2Dcache_response = '0;
    if (grant_i) begin
      proc2mem_command     = Icache2mem_command;
      proc2mem_addr        = Icache2mem_addr;
      Imem2Icache_response = mem2proc_response;
    end else if (grant_d) begin
      proc2mem_command     = Dcache2mem_command;
      proc2mem_addr        = Dcache2mem_addr;
      proc2mem_data        = Dcache2mem_data;
      Dmem2Dcache_response = mem2proc_response;
    end
  end

  always_comb begin
    Imem2Icache_tag  = '0;
    Imem2Icache_data = '0;
    Dmem2Dcache_tag  = '0;
    Dmem2Dcache_data = '0;
    if (hit) begin
      if (hit_is_d) begin
        Dmem2Dcache_tag  = mem2proc_tag;
        Dmem2Dcache_data = mem2proc_data;
      end else begin
        Imem2Icache_tag  = mem2proc_tag;
        Imem2Icache_data = mem2proc_data;
      end
    end
  end

  // Only an accepted I-side request resets starvation; a refused I grant
  // keeps the count so the I-side stays prioritised next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_i && mem2proc_response != '0) begin
      starve_cnt <= '0;
    end else if (i_active && !grant_i && starve_cnt != '1) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  mem_tag_owner_table u_owner_table (
    .clock      (clock),
    .reset      (reset),
    .set_en     (accepted),
    .set_tag    (mem2proc_response),
    .set_is_d   (grant_d),
    .lookup_tag (mem2proc_tag),
    .hit        (hit),
    .hit_is_d   (hit_is_d),
    .orphan     (orphan_tag)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic        clock;
  logic        reset;
  logic [1:0]  icmd, dcmd;
  logic [63:0] iaddr, daddr, ddata, mdata;
  logic [3:0]  resp, tag;
  logic [1:0]  pcmd;
  logic [63:0] paddr, pdata, idata_o, ddata_o;
  logic [3:0]  iresp, itag, dresp, dtag;
  logic        gi, orph;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_BITS(3)) dut (
    .clock                (clock),
    .reset                (reset),
    .Icache2mem_command   (icmd),
    .Icache2mem_addr      (iaddr),
    .Dcache2mem_command   (dcmd),
    .Dcache2mem_addr      (daddr),
    .Dcache2mem_data      (ddata),
    .mem2proc_response    (resp),
    .mem2proc_tag         (tag),
    .mem2proc_data        (mdata),
    .proc2mem_command     (pcmd),
    .proc2mem_addr        (paddr),
    .proc2mem_data        (pdata),
    .Imem2Icache_response (iresp),
    .Imem2Icache_tag      (itag),
    .Imem2Icache_data     (idata_o),
    .Dmem2Dcache_response (dresp),
    .Dmem2Dcache_tag      (dtag),
    .Dmem2Dcache_data     (ddata_o),
    .grant_i              (gi),
    .orphan_tag           (orph)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  icmd;  logic [63:0] iaddr;
    logic [1:0]  dcmd;  logic [63:0] daddr; logic [63:0] ddata;
    logic [3:0]  resp;  logic [3:0]  tag;   logic [63:0] mdata;
    logic [1:0]  e_pcmd; logic [63:0] e_paddr; logic [63:0] e_pdata;
    logic [3:0]  e_iresp; logic [3:0] e_itag; logic [63:0] e_idata;
    logic [3:0]  e_dresp; logic [3:0] e_dtag; logic [63:0] e_ddata;
    logic        e_gi;   logic        e_orph;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] ic, input logic [63:0] ia, input logic [1:0] dc,
                       input logic [63:0] da, input logic [63:0] dd, input logic [3:0] r,
                       input logic [3:0] t, input logic [63:0] md);
    icmd = ic; iaddr = ia; dcmd = dc; daddr = da; ddata = dd;
    resp = r; tag = t; mdata = md;
  endtask

  task automatic idle();
    drive(BUS_NONE, '0, BUS_NONE, '0, '0, '0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  int cnt_model;
  int i_grants;
  int last_gi_cycle;
  logic exp_gi;
  logic refused;

  initial begin
    reset = 1'b0;
    idle();
    #2;
    // reset state: everything idle reads zero / BUS_NONE
    @(negedge clock);
    chk("rst_pcmd", pcmd, BUS_NONE);
    chk("rst_paddr", paddr, 64'h0);
    chk("rst_iresp", iresp, 4'h0);
    chk("rst_dresp", dresp, 4'h0);
    chk("rst_gi", gi, 1'b0);
    chk("rst_orph", orph, 1'b0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    vecs[0]  = '{BUS_NONE, 64'h0,  BUS_NONE,  64'h0,   64'h0,    4'd0, 4'd0, 64'h0,
                 BUS_NONE, 64'h0,  64'h0,     4'd0, 4'd0, 64'h0,  4'd0, 4'd0, 64'h0,   1'b0, 1'b0};
    vecs[1]  = '{BUS_NONE, 64'h0,  BUS_LOAD,  64'h100, 64'h0,    4'd5, 4'd0, 64'h0,
                 BUS_LOAD, 64'h100, 64'h0,    4'd0, 4'd0, 64'h0,  4'd5, 4'd0, 64'h0,   1'b0, 1'b0};
    vecs[2]  = vecs[0];
    vecs[3]  = vecs[0];
    vecs[4]  = '{BUS_NONE, 64'h0,  BUS_NONE,  64'h0,   64'h0,    4'd0, 4'd5, 64'hDEAD,
                 BUS_NONE, 64'h0,  64'h0,     4'd0, 4'd0, 64'h0,  4'd0, 4'd5, 64'hDEAD, 1'b0, 1'b0};
    vecs[5]  = '{BUS_NONE, 64'h0,  BUS_NONE,  64'h0,   64'h0,    4'd0, 4'd5, 64'hBEEF,
                 BUS_NONE, 64'h0,  64'h0,     4'd0, 4'd0, 64'h0,  4'd0, 4'd0, 64'h0,   1'b0, 1'b1};
    vecs[6]  = '{BUS_NONE, 64'h0,  BUS_NONE,  64'h0,   64'h0,    4'd0, 4'd9, 64'h9999,
                 BUS_NONE, 64'h0,  64'h0,     4'd0, 4'd0, 64'h0,  4'd0, 4'd0, 64'h0,   1'b0, 1'b1};
    vecs[7]  = '{BUS_LOAD, 64'h200, BUS_NONE, 64'h0,   64'h0,    4'd2, 4'd0, 64'h0,
                 BUS_LOAD, 64'h200, 64'h0,    4'd2, 4'd0, 64'h0,  4'd0, 4'd0, 64'h0,   1'b1, 1'b0};
    vecs[8]  = '{BUS_NONE, 64'h0,  BUS_STORE, 64'h300, 64'hABCD, 4'd7, 4'd0, 64'h0,
                 BUS_STORE, 64'h300, 64'hABCD, 4'd0, 4'd0, 64'h0, 4'd7, 4'd0, 64'h0,   1'b0, 1'b0};
    vecs[9]  = '{BUS_NONE, 64'h0,  BUS_NONE,  64'h0,   64'h0,    4'd0, 4'd2, 64'h1111,
                 BUS_NONE, 64'h0,  64'h0,     4'd0, 4'd2, 64'h1111, 4'd0, 4'd0, 64'h0, 1'b0, 1'b0};
    vecs[10] = '{BUS_NONE, 64'h0,  BUS_NONE,  64'h0,   64'h0,    4'd0, 4'd7, 64'h7777,
                 BUS_NONE, 64'h0,  64'h0,     4'd0, 4'd0, 64'h0,  4'd0, 4'd7, 64'h7777, 1'b0, 1'b0};
    vecs[11] = '{BUS_LOAD, 64'h40, BUS_NONE,  64'h555, 64'h666,  4'd0, 4'd0, 64'h0,
                 BUS_LOAD, 64'h40, 64'h0,     4'd0, 4'd0, 64'h0,  4'd0, 4'd0, 64'h0,   1'b1, 1'b0};

    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].icmd, vecs[v].iaddr, vecs[v].dcmd, vecs[v].daddr, vecs[v].ddata,
            vecs[v].resp, vecs[v].tag, vecs[v].mdata);
      @(negedge clock);
      chk($sformatf("v%0d_pcmd", v),  pcmd,    vecs[v].e_pcmd);
      chk($sformatf("v%0d_paddr", v), paddr,   vecs[v].e_paddr);
      chk($sformatf("v%0d_pdata", v), pdata,   vecs[v].e_pdata);
      chk($sformatf("v%0d_iresp", v), iresp,   vecs[v].e_iresp);
      chk($sformatf("v%0d_itag", v),  itag,    vecs[v].e_itag);
      chk($sformatf("v%0d_idata", v), idata_o, vecs[v].e_idata);
      chk($sformatf("v%0d_dresp", v), dresp,   vecs[v].e_dresp);
      chk($sformatf("v%0d_dtag", v),  dtag,    vecs[v].e_dtag);
      chk($sformatf("v%0d_ddata", v), ddata_o, vecs[v].e_ddata);
      chk($sformatf("v%0d_gi", v),    gi,      vecs[v].e_gi);
      chk($sformatf("v%0d_orph", v),  orph,    vecs[v].e_orph);
      next_cycle();
    end

    // Starvation: both sides loading, memory always accepts (counter starts at 0)
    cnt_model = 0;
    for (int c = 1; c <= 10; c++) begin
      drive(BUS_LOAD, 64'h1000, BUS_LOAD, 64'h2000, 64'h0, 4'd1, 4'd0, 64'h0);
      exp_gi = (cnt_model >= LIMIT);
      @(negedge clock);
      chk($sformatf("st%0d_gi", c), gi, exp_gi);
      chk($sformatf("st%0d_iresp", c), iresp, exp_gi ? 4'd1 : 4'd0);
      chk($sformatf("st%0d_dresp", c), dresp, exp_gi ? 4'd0 : 4'd1);
      chk($sformatf("st%0d_paddr", c), paddr, exp_gi ? 64'h1000 : 64'h2000);
      if (exp_gi) cnt_model = 0;
      else if (cnt_model < 7) cnt_model++;
      next_cycle();
    end

    // Refused I grant: memory answers 0 on the first I-grant cycle
    refused = 1'b0;
    i_grants = 0;
    last_gi_cycle = -10;
    for (int c = 1; c <= 8; c++) begin
      exp_gi = (cnt_model >= LIMIT);
      drive(BUS_LOAD, 64'h1000, BUS_LOAD, 64'h2000, 64'h0,
            (exp_gi && !refused) ? 4'd0 : 4'd1, 4'd0, 64'h0);
      @(negedge clock);
      chk($sformatf("rf%0d_gi", c), gi, exp_gi);
      if (gi) begin
        i_grants++;
        if (i_grants == 2) chk("rf_consecutive", c - last_gi_cycle, 1);
        last_gi_cycle = c;
      end
      if (exp_gi && resp != 0) cnt_model = 0;
      else if (!exp_gi && cnt_model < 7) cnt_model++;
      if (exp_gi) refused = 1'b1;
      next_cycle();
    end
    chk("rf_i_grants", i_grants, 2);

    // Same tag returned and reissued in one cycle: set wins with new owner
    do_reset();
    drive(BUS_LOAD, 64'h30, BUS_NONE, '0, '0, 4'd3, 4'd0, '0);
    @(negedge clock);
    chk("sw_issue_iresp", iresp, 4'd3);
    next_cycle();
    drive(BUS_NONE, '0, BUS_STORE, 64'h330, 64'h55, 4'd3, 4'd3, 64'h33);
    @(negedge clock);
    chk("sw_itag", itag, 4'd3);
    chk("sw_idata", idata_o, 64'h33);
    chk("sw_dtag", dtag, 4'd0);
    chk("sw_dresp", dresp, 4'd3);
    chk("sw_orph", orph, 1'b0);
    next_cycle();
    drive(BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, 4'd3, 64'h44);
    @(negedge clock);
    chk("sw_later_dtag", dtag, 4'd3);
    chk("sw_later_ddata", ddata_o, 64'h44);
    chk("sw_later_itag", itag, 4'd0);
    next_cycle();
    drive(BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, 4'd3, 64'h44);
    @(negedge clock);
    chk("sw_freed_orph", orph, 1'b1);
    next_cycle();

    // Asynchronous reset mid-flight flushes the owner table
    drive(BUS_LOAD, 64'h20, BUS_NONE, '0, '0, 4'd2, 4'd0, '0);
    next_cycle();
    drive(BUS_NONE, '0, BUS_LOAD, 64'h70, '0, 4'd7, 4'd0, '0);
    next_cycle();
    idle();
    #2 reset = 1'b0;
    #1;
    chk("ar_pcmd_in_reset", pcmd, BUS_NONE);
    @(negedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    drive(BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, 4'd7, 64'h77);
    @(negedge clock);
    chk("ar_tag7_orph", orph, 1'b1);
    chk("ar_tag7_dtag", dtag, 4'd0);
    chk("ar_tag7_itag", itag, 4'd0);
    next_cycle();
    drive(BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, 4'd2, 64'h22);
    @(negedge clock);
    chk("ar_tag2_orph", orph, 1'b1);
    chk("ar_tag2_itag", itag, 4'd0);
    next_cycle();
    // starvation counter cleared: D wins a contested cycle again
    drive(BUS_LOAD, 64'h1, BUS_LOAD, 64'h2, '0, 4'd1, 4'd0, '0);
    @(negedge clock);
    chk("ar_gi_after_reset", gi, 1'b0);
    next_cycle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
